// File: rtl/tensor_core_scheduler.sv
// tensor_core_scheduler
// Moves one job's operand block (ELEMENT_COUNT bytes) from the CPU register
// file into the tensor-core register file, then waits for the tensor core's
// completion strobe. The wait is bounded by TIMEOUT_CYCLES.
//
// Flow: IDLE -> LOAD (one byte per cycle) -> WAIT -> FINISH -> IDLE.
// abort_in returns the block to IDLE from any state. A timeout also returns
// to IDLE and sets a sticky error flag.
//
// All control outputs come straight from flops, which are loaded from the
// next-state values. tc_write_data_out is the one exception: the CPU register
// file returns read data combinationally, so that data is gated by the
// registered write enable and passed through in the same cycle.
module tensor_core_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ELEMENT_COUNT  = 32
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       start_in,
  input  logic       abort_in,
  input  logic [7:0] src_base_in,
  output logic [7:0] cpu_read_address_out,
  input  logic [7:0] cpu_read_data_in,
  output logic       tc_write_enable_out,
  output logic [4:0] tc_write_address_out,
  output logic [7:0] tc_write_data_out,
  input  logic       tc_done_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       timeout_error_out,
  output logic [7:0] jobs_completed_out
);

  localparam int IDX_W  = (ELEMENT_COUNT  > 1) ? $clog2(ELEMENT_COUNT)  : 1;
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST_C  = IDX_W'(ELEMENT_COUNT - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE_C   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ZERO_C  = IDX_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE_C  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO_C = WAIT_W'(0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Architectural state
  logic [1:0]        state_r;
  logic [IDX_W-1:0]  index_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [7:0]        base_r;
  logic              timeout_error_r;
  logic [7:0]        jobs_completed_r;

  // Registered outputs
  logic              busy_r;
  logic              done_r;
  logic              tc_write_enable_r;
  logic [4:0]        tc_write_address_r;
  logic [7:0]        cpu_read_address_r;

  // Next-state values
  logic [1:0]        state_nx_s;
  logic [IDX_W-1:0]  index_nx_s;
  logic [WAIT_W-1:0] wait_cnt_nx_s;
  logic [7:0]        base_nx_s;
  logic              timeout_error_nx_s;
  logic [7:0]        jobs_completed_nx_s;

  // Next-state logic; abort has priority over every transition, including
  // a start request in IDLE.
  always_comb begin
    state_nx_s          = state_r;
    index_nx_s          = index_r;
    wait_cnt_nx_s       = wait_cnt_r;
    base_nx_s           = base_r;
    timeout_error_nx_s  = timeout_error_r;
    jobs_completed_nx_s = jobs_completed_r;
    if (abort_in) begin
      state_nx_s    = ST_IDLE;
      index_nx_s    = IDX_ZERO_C;
      wait_cnt_nx_s = WAIT_ZERO_C;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            state_nx_s         = ST_LOAD;
            base_nx_s          = src_base_in;
            index_nx_s         = IDX_ZERO_C;
            wait_cnt_nx_s      = WAIT_ZERO_C;
            timeout_error_nx_s = 1'b0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (index_r == IDX_LAST_C) begin
            state_nx_s    = ST_WAIT;
            index_nx_s    = IDX_ZERO_C;
            wait_cnt_nx_s = WAIT_ZERO_C;
          end else begin
            index_nx_s = index_r + IDX_ONE_C;
          end
        end
        ST_WAIT: begin
          // A completion strobe on the last allowed cycle still counts as
          // success, so tc_done_in is tested before the timeout.
          if (tc_done_in) begin
            state_nx_s          = ST_FINISH;
            jobs_completed_nx_s = jobs_completed_r + 8'd1;
          end else if (wait_cnt_r == WAIT_LAST_C) begin
            state_nx_s         = ST_IDLE;
            wait_cnt_nx_s      = WAIT_ZERO_C;
            timeout_error_nx_s = 1'b1;
          end else begin
            wait_cnt_nx_s = wait_cnt_r + WAIT_ONE_C;
          end
        end
        ST_FINISH: begin
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s    = ST_IDLE;
          index_nx_s    = IDX_ZERO_C;
          wait_cnt_nx_s = WAIT_ZERO_C;
        end
      endcase
    end
  end

  // State registers; reset drops any in-flight job immediately
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r          <= ST_IDLE;
      index_r          <= IDX_ZERO_C;
      wait_cnt_r       <= WAIT_ZERO_C;
      base_r           <= 8'd0;
      timeout_error_r  <= 1'b0;
      jobs_completed_r <= 8'd0;
    end else begin
      state_r          <= state_nx_s;
      index_r          <= index_nx_s;
      wait_cnt_r       <= wait_cnt_nx_s;
      base_r           <= base_nx_s;
      timeout_error_r  <= timeout_error_nx_s;
      jobs_completed_r <= jobs_completed_nx_s;
    end
  end

  // Output registers, loaded from next-state values so that each output
  // lines up with the state it describes
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      tc_write_enable_r  <= 1'b0;
      tc_write_address_r <= 5'd0;
      cpu_read_address_r <= 8'd0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= (state_nx_s == ST_FINISH);
      if (state_nx_s == ST_LOAD) begin
        tc_write_enable_r  <= 1'b1;
        tc_write_address_r <= 5'(index_nx_s);
        cpu_read_address_r <= base_nx_s + 8'(index_nx_s);
      end else begin
        tc_write_enable_r  <= 1'b0;
        tc_write_address_r <= 5'd0;
        cpu_read_address_r <= 8'd0;
      end
    end
  end

  assign busy_out             = busy_r;
  assign done_out             = done_r;
  assign timeout_error_out    = timeout_error_r;
  assign jobs_completed_out   = jobs_completed_r;
  assign tc_write_enable_out  = tc_write_enable_r;
  assign tc_write_address_out = tc_write_address_r;
  assign cpu_read_address_out = cpu_read_address_r;
  // The write data is zero outside LOAD, so WAIT can never produce a write
  // that would restart the tensor core.
  assign tc_write_data_out    = tc_write_enable_r ? cpu_read_data_in : 8'd0;

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Testbench for tensor_core_scheduler. A CPU register file model supplies
// read data. The expected writes, completion timing and job count come from
// the job rules: load N bytes, wait for done or time out, then finish.
module tb_tensor_core_scheduler;

  localparam int TO = 64;
  localparam int EC = 32;

  logic       clock_in = 1'b0;
  logic       reset_n_in;
  logic       start_in;
  logic       abort_in;
  logic [7:0] src_base_in;
  logic [7:0] cpu_read_address_out;
  logic [7:0] cpu_read_data_in;
  logic       tc_write_enable_out;
  logic [4:0] tc_write_address_out;
  logic [7:0] tc_write_data_out;
  logic       tc_done_in;
  logic       busy_out;
  logic       done_out;
  logic       timeout_error_out;
  logic [7:0] jobs_completed_out;

  logic [7:0] mem [256];
  int vectors    = 0;
  int miscompares = 0;
  int exp_count  = 0;

  assign cpu_read_data_in = mem[cpu_read_address_out];

  always #5 clock_in = ~clock_in;

  tensor_core_scheduler #(.TIMEOUT_CYCLES(TO), .ELEMENT_COUNT(EC)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in), .start_in(start_in),
    .abort_in(abort_in), .src_base_in(src_base_in),
    .cpu_read_address_out(cpu_read_address_out), .cpu_read_data_in(cpu_read_data_in),
    .tc_write_enable_out(tc_write_enable_out), .tc_write_address_out(tc_write_address_out),
    .tc_write_data_out(tc_write_data_out), .tc_done_in(tc_done_in),
    .busy_out(busy_out), .done_out(done_out), .timeout_error_out(timeout_error_out),
    .jobs_completed_out(jobs_completed_out)
  );

  task automatic apply_reset();
    reset_n_in = 1'b0;
    repeat (2) @(negedge clock_in);
    reset_n_in = 1'b1;
    exp_count = 0;
  endtask

  // Runs one job from an IDLE negedge. A delay of d places tc_done_in in WAIT
  // cycle d. With timeout set, tc_done_in is never raised. With hold set,
  // start_in stays high for the whole job.
  task automatic run_job(input logic [7:0] base, input int delay, input bit timeout, input bit hold);
    logic [7:0] a;
    bit fired;
    src_base_in = base; start_in = 1'b1; abort_in = 1'b0; tc_done_in = 1'b0;
    @(negedge clock_in);
    if (!hold) start_in = 1'b0;
    src_base_in = 8'($urandom);
    for (int k = 0; k < EC; k++) begin
      a = base + 8'(k);
      vectors++;
      if ({busy_out, tc_write_enable_out, tc_write_address_out, cpu_read_address_out,
           tc_write_data_out, done_out, timeout_error_out} !==
          {1'b1, 1'b1, 5'(k), a, mem[a], 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL load[%0d]: busy=%b we=%b waddr=%0d raddr=%h wdata=%h done=%b err=%b, required 1 1 %0d %h %h 0 0",
                 k, busy_out, tc_write_enable_out, tc_write_address_out, cpu_read_address_out,
                 tc_write_data_out, done_out, timeout_error_out, k, a, mem[a]);
      end
      vectors++;
      if (jobs_completed_out !== 8'(exp_count)) begin
        miscompares++;
        $display("FAIL load_count: got %0d, required %0d", jobs_completed_out, exp_count);
      end
      tc_done_in = 1'($urandom_range(0, 1));
      @(negedge clock_in);
    end
    fired = 1'b0;
    for (int w = 0; w < TO; w++) begin
      tc_done_in = 1'b0;
      vectors++;
      if ({busy_out, tc_write_enable_out, tc_write_address_out, cpu_read_address_out,
           tc_write_data_out, done_out, timeout_error_out} !== {1'b1, 1'b0, 5'd0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL wait[%0d]: busy=%b we=%b waddr=%0d raddr=%h wdata=%h done=%b err=%b, required 1 0 0 00 00 0 0",
                 w, busy_out, tc_write_enable_out, tc_write_address_out, cpu_read_address_out,
                 tc_write_data_out, done_out, timeout_error_out);
      end
      if (!timeout && w == delay) begin
        tc_done_in = 1'b1;
        fired = 1'b1;
      end
      @(negedge clock_in);
      if (fired) break;
    end
    tc_done_in = 1'b0;
    if (fired) begin
      exp_count = (exp_count + 1) % 256;
      vectors++;
      if ({busy_out, done_out, timeout_error_out, tc_write_enable_out} !== 4'b1100) begin
        miscompares++;
        $display("FAIL finish: busy/done/err/we=%b%b%b%b, required 1100",
                 busy_out, done_out, timeout_error_out, tc_write_enable_out);
      end
      vectors++;
      if (jobs_completed_out !== 8'(exp_count)) begin
        miscompares++;
        $display("FAIL finish_count: got %0d, required %0d", jobs_completed_out, exp_count);
      end
      @(negedge clock_in);
      vectors++;
      if ({busy_out, done_out, tc_write_enable_out} !== 3'b000) begin
        miscompares++;
        $display("FAIL after_finish: busy/done/we=%b%b%b, required 000", busy_out, done_out, tc_write_enable_out);
      end
    end else begin
      vectors++;
      if ({busy_out, done_out, timeout_error_out, tc_write_enable_out} !== 4'b0010) begin
        miscompares++;
        $display("FAIL timeout: busy/done/err/we=%b%b%b%b, required 0010",
                 busy_out, done_out, timeout_error_out, tc_write_enable_out);
      end
      vectors++;
      if (jobs_completed_out !== 8'(exp_count)) begin
        miscompares++;
        $display("FAIL timeout_count: got %0d, required %0d", jobs_completed_out, exp_count);
      end
    end
  endtask

  task automatic test_reset();
    start_in = 1'b0; abort_in = 1'b0; tc_done_in = 1'b0; src_base_in = 8'd0;
    apply_reset();
    vectors++;
    if ({busy_out, done_out, timeout_error_out, jobs_completed_out, tc_write_enable_out,
         tc_write_address_out, tc_write_data_out, cpu_read_address_out} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b err=%b count=%0d we=%b waddr=%0d wdata=%h raddr=%h, required all 0",
               busy_out, done_out, timeout_error_out, jobs_completed_out, tc_write_enable_out,
               tc_write_address_out, tc_write_data_out, cpu_read_address_out);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < EC; k++) mem[8'h10 + k] = 8'(k + 1);
    run_job(8'h10, 5, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_job(8'($urandom), 0, 1'b1, 1'b0);
    repeat (3) @(negedge clock_in);
    vectors++;
    if (timeout_error_out !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: err=%b, required 1", timeout_error_out);
    end
    // The next accepted start clears the flag; run_job checks it in LOAD.
    run_job(8'($urandom), TO - 1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_job(8'hF0, int'($urandom_range(0, TO - 1)), 1'b0, 1'b0);
  endtask

  task automatic test_contention();
    run_job(8'($urandom), 3, 1'b0, 1'b1);
    start_in = 1'b1; abort_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_in);
      vectors++;
      if ({busy_out, tc_write_enable_out, done_out} !== 3'b000) begin
        miscompares++;
        $display("FAIL start_abort[%0d]: busy/we/done=%b%b%b, required 000", i, busy_out, tc_write_enable_out, done_out);
      end
    end
    start_in = 1'b0; abort_in = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] base;
    logic [7:0] a;
    base = 8'($urandom);
    src_base_in = base; start_in = 1'b1;
    @(negedge clock_in);
    start_in = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      a = base + 8'(k);
      vectors++;
      if ({tc_write_enable_out, tc_write_address_out, cpu_read_address_out} !== {1'b1, 5'(k), a}) begin
        miscompares++;
        $display("FAIL abort_load[%0d]: we=%b waddr=%0d raddr=%h, required 1 %0d %h",
                 k, tc_write_enable_out, tc_write_address_out, cpu_read_address_out, k, a);
      end
      tc_done_in = 1'b1;
      if (k == 10) abort_in = 1'b1;
      @(negedge clock_in);
    end
    abort_in = 1'b0; tc_done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({busy_out, tc_write_enable_out, done_out, cpu_read_address_out, tc_write_data_out} !== 19'd0 ||
          jobs_completed_out !== 8'(exp_count)) begin
        miscompares++;
        $display("FAIL aborted[%0d]: busy=%b we=%b done=%b raddr=%h wdata=%h count=%0d, required 0 0 0 00 00 %0d",
                 i, busy_out, tc_write_enable_out, done_out, cpu_read_address_out, tc_write_data_out,
                 jobs_completed_out, exp_count);
      end
      @(negedge clock_in);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int j = 0; j < 12; j++)
      run_job(8'($urandom), int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 3) == 0), 1'b0);
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int j = 0; j < 256; j++) run_job(8'($urandom), 0, 1'b0, 1'b0);
    vectors++;
    if (jobs_completed_out !== 8'd0) begin
      miscompares++;
      $display("FAIL count_wrap: got %0d, required 0", jobs_completed_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int j = 0; j < 255; j++) run_job(8'($urandom), 0, 1'b0, 1'b0);
    src_base_in = 8'($urandom); start_in = 1'b1;
    @(negedge clock_in);
    start_in = 1'b0;
    repeat (EC + 4) @(negedge clock_in);
    vectors++;
    if ({busy_out, jobs_completed_out} !== {1'b1, 8'd255}) begin
      miscompares++;
      $display("FAIL pre_reset: busy=%b count=%0d, required 1 255", busy_out, jobs_completed_out);
    end
    #2 reset_n_in = 1'b0;
    #1;
    vectors++;
    if ({busy_out, done_out, timeout_error_out, jobs_completed_out, tc_write_enable_out,
         tc_write_address_out, tc_write_data_out, cpu_read_address_out} !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b err=%b count=%0d we=%b waddr=%0d wdata=%h raddr=%h, required all 0",
               busy_out, done_out, timeout_error_out, jobs_completed_out, tc_write_enable_out,
               tc_write_address_out, tc_write_data_out, cpu_read_address_out);
    end
    @(negedge clock_in);
    reset_n_in = 1'b1;
    exp_count = 0;
    @(negedge clock_in);
    run_job(8'($urandom), 7, 1'b0, 1'b0);
    vectors++;
    if (jobs_completed_out !== 8'd1) begin
      miscompares++;
      $display("FAIL count_after_reset: got %0d, required 1", jobs_completed_out);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    test_reset();
    test_basic();
    test_timeout();
    test_wrap();
    test_contention();
    test_abort();
    test_random();
    test_count_wrap();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
